// File: rtl/simt_update_sched_if.sv
// Request channel from the SIMT update scheduler to the SIMT stack update port.
// The scheduler drives the master side; the stack (or a bench) uses the slave side.
interface simt_update_sched_if #(
  parameter int PC_W = 32
);
  logic            ReqValid_Sched_SIMT;
  logic            ReqReady_SIMT_Sched;
  logic [2:0]      ReqOp_Sched_SIMT;
  logic [2:0]      ReqWarpID_Sched_SIMT;
  logic [PC_W-1:0] ReqPCplus4_Sched_SIMT;
  logic [7:0]      ReqMask_Sched_SIMT;

  modport master (
    output ReqValid_Sched_SIMT,
    output ReqOp_Sched_SIMT,
    output ReqWarpID_Sched_SIMT,
    output ReqPCplus4_Sched_SIMT,
    output ReqMask_Sched_SIMT,
    input  ReqReady_SIMT_Sched
  );

  modport slave (
    input  ReqValid_Sched_SIMT,
    input  ReqOp_Sched_SIMT,
    input  ReqWarpID_Sched_SIMT,
    input  ReqPCplus4_Sched_SIMT,
    input  ReqMask_Sched_SIMT,
    output ReqReady_SIMT_Sched
  );
endinterface

// File: rtl/simt_update_sched.sv
// Serialises dual-lane decode control-flow ops and ALU branch outcomes onto the SIMT stack update port.
// Optional performance counters are built when SCHED_PERF_CNT_EN is defined.
module simt_update_sched #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Valid_ID0_Sched,
  input  logic [2:0]           WarpID_ID0_Sched,
  input  logic [2:0]           Op_ID0_Sched,
  input  logic [PC_W-1:0]      PCplus4_ID0_Sched,
  input  logic                 Valid_ID1_Sched,
  input  logic [2:0]           WarpID_ID1_Sched,
  input  logic [2:0]           Op_ID1_Sched,
  input  logic [PC_W-1:0]      PCplus4_ID1_Sched,
  input  logic                 Br_ALU_Sched,
  input  logic [2:0]           WarpID_ALU_Sched,
  input  logic [7:0]           BrOutcome_ALU_Sched,
  simt_update_sched_if.master  req,
  output logic [7:0]           Stall_Sched_PC,
  output logic                 Overflow_Sched
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]          IssueCnt_Sched,
  output logic [15:0]          StallCnt_Sched
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] OP_BEQ     = 3'd1;
  localparam logic [2:0] OP_BLT     = 3'd2;
  localparam logic [2:0] OP_OUTCOME = 3'd7;

  logic [2:0]       fifoOp_q   [DEPTH];
  logic [2:0]       fifoWarp_q [DEPTH];
  logic [PC_W-1:0]  fifoPc_q   [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d, slot1;
  logic [CNT_W-1:0] cnt_q, cnt_d, freeSlots, freeEff;

  logic [2:0] aluWarp_q [2];
  logic [7:0] aluMask_q [2];
  logic       aluRd_q, aluRd_d, aluWr_q, aluWr_d;
  logic [1:0] aluCnt_q, aluCnt_d;

  logic [7:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic       lock_q, lock_d, lockAlu_q, lockAlu_d;

  logic       valid0, valid1, isBr0, isBr1, acc0, acc1;
  logic       aluPush, aluElig, selAlu, selFifo, reqValid, popAlu, popFifo;
  logic [2:0] aluHeadWarp;
  logic [7:0] brq;

  always_comb begin
    valid0 = Valid_ID0_Sched && (Op_ID0_Sched != 3'd0) && (Op_ID0_Sched != 3'd7);
    valid1 = Valid_ID1_Sched && (Op_ID1_Sched != 3'd0) && (Op_ID1_Sched != 3'd7);
    isBr0  = (Op_ID0_Sched == OP_BEQ) || (Op_ID0_Sched == OP_BLT);
    isBr1  = (Op_ID1_Sched == OP_BEQ) || (Op_ID1_Sched == OP_BLT);
  end

  // A warp whose branch is still queued must not see its outcome overtake it.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = '0;
    brq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) &&
          ((fifoOp_q[idx] == OP_BEQ) || (fifoOp_q[idx] == OP_BLT)))
        brq[fifoWarp_q[idx]] = 1'b1;
    end
  end

  // The lock freezes the chosen source while a request waits, so the payload cannot switch under the stack.
  always_comb begin
    aluHeadWarp = aluWarp_q[aluRd_q];
    aluElig     = (aluCnt_q != 2'd0) && !brq[aluHeadWarp];
    selAlu      = lock_q ? lockAlu_q  : aluElig;
    selFifo     = lock_q ? !lockAlu_q : (!aluElig && (cnt_q != '0));
    reqValid    = selAlu || selFifo;
    popAlu      = reqValid && req.ReqReady_SIMT_Sched && selAlu;
    popFifo     = reqValid && req.ReqReady_SIMT_Sched && selFifo;
    lock_d      = reqValid && !req.ReqReady_SIMT_Sched;
    lockAlu_d   = selAlu;
  end

  always_comb begin
    freeSlots  = CNT_W'(DEPTH) - cnt_q;
    freeEff    = freeSlots + CNT_W'(popFifo);
    acc0       = valid0 && (freeEff != '0);
    acc1       = valid1 && (freeEff > CNT_W'(acc0));
    slot1      = wrPtr_q + PTR_W'(acc0);
    wrPtr_d    = wrPtr_q + PTR_W'(acc0) + PTR_W'(acc1);
    rdPtr_d    = rdPtr_q + PTR_W'(popFifo);
    cnt_d      = cnt_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(popFifo);

    // A full outcome buffer drops the new outcome even if its head leaves this cycle.
    aluPush    = Br_ALU_Sched && (aluCnt_q != 2'd2);
    aluWr_d    = aluWr_q ^ aluPush;
    aluRd_d    = aluRd_q ^ popAlu;
    aluCnt_d   = aluCnt_q + 2'(aluPush) - 2'(popAlu);

    overflow_d = overflow_q
               || (valid0 && !acc0) || (valid1 && !acc1)
               || (Br_ALU_Sched && !aluPush);

    pending_d = pending_q;
    if (popAlu)
      pending_d[aluHeadWarp] = 1'b0;
    if (acc0 && isBr0)
      pending_d[WarpID_ID0_Sched] = 1'b1;
    if (acc1 && isBr1)
      pending_d[WarpID_ID1_Sched] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      cnt_q      <= '0;
      aluRd_q    <= 1'b0;
      aluWr_q    <= 1'b0;
      aluCnt_q   <= 2'd0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      lock_q     <= 1'b0;
      lockAlu_q  <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      cnt_q      <= cnt_d;
      aluRd_q    <= aluRd_d;
      aluWr_q    <= aluWr_d;
      aluCnt_q   <= aluCnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      lock_q     <= lock_d;
      lockAlu_q  <= lockAlu_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counts above.
  always_ff @(posedge clk) begin
    if (acc0) begin
      fifoOp_q[wrPtr_q]   <= Op_ID0_Sched;
      fifoWarp_q[wrPtr_q] <= WarpID_ID0_Sched;
      fifoPc_q[wrPtr_q]   <= PCplus4_ID0_Sched;
    end
    if (acc1) begin
      fifoOp_q[slot1]     <= Op_ID1_Sched;
      fifoWarp_q[slot1]   <= WarpID_ID1_Sched;
      fifoPc_q[slot1]     <= PCplus4_ID1_Sched;
    end
    if (aluPush) begin
      aluWarp_q[aluWr_q]  <= WarpID_ALU_Sched;
      aluMask_q[aluWr_q]  <= BrOutcome_ALU_Sched;
    end
  end

  always_comb begin
    req.ReqValid_Sched_SIMT   = reqValid;
    req.ReqOp_Sched_SIMT      = 3'd0;
    req.ReqWarpID_Sched_SIMT  = 3'd0;
    req.ReqPCplus4_Sched_SIMT = '0;
    req.ReqMask_Sched_SIMT    = 8'd0;
    if (selAlu) begin
      req.ReqOp_Sched_SIMT      = OP_OUTCOME;
      req.ReqWarpID_Sched_SIMT  = aluHeadWarp;
      req.ReqMask_Sched_SIMT    = aluMask_q[aluRd_q];
    end else if (selFifo) begin
      req.ReqOp_Sched_SIMT      = fifoOp_q[rdPtr_q];
      req.ReqWarpID_Sched_SIMT  = fifoWarp_q[rdPtr_q];
      req.ReqPCplus4_Sched_SIMT = fifoPc_q[rdPtr_q];
    end
  end

  assign Stall_Sched_PC = pending_q | {8{freeSlots < CNT_W'(2)}};
  assign Overflow_Sched = overflow_q;

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] issueCnt_q, issueCnt_d, stallCnt_q, stallCnt_d;

  always_comb begin
    issueCnt_d = issueCnt_q;
    stallCnt_d = stallCnt_q;
    if ((popAlu || popFifo) && (issueCnt_q != 16'hFFFF))
      issueCnt_d = issueCnt_q + 16'd1;
    if (lock_d && (stallCnt_q != 16'hFFFF))
      stallCnt_d = stallCnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issueCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      issueCnt_q <= issueCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign IssueCnt_Sched = issueCnt_q;
  assign StallCnt_Sched = stallCnt_q;
`endif

endmodule

// File: tb/tb_simt_update_sched.sv
// Self-checking bench for simt_update_sched: vector table plus scoreboard of issued requests.
// Counter checks are compiled in when SCHED_PERF_CNT_EN is defined.
module tb_simt_update_sched;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst;
  logic ready;
  logic v0, v1, br;
  logic [2:0] op0, w0, op1, w1, bw;
  logic [PC_W-1:0] pc0, pc1;
  logic [7:0] bm;
  logic [7:0] stall;
  logic overflow;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0] issueCnt, stallCnt;
`endif

  always #5 clk = ~clk;

  simt_update_sched_if #(.PC_W(PC_W)) reqIf ();
  assign reqIf.ReqReady_SIMT_Sched = ready;

  logic            reqValid;
  logic [2:0]      reqOp, reqWarp;
  logic [PC_W-1:0] reqPc;
  logic [7:0]      reqMask;
  assign reqValid = reqIf.ReqValid_Sched_SIMT;
  assign reqOp    = reqIf.ReqOp_Sched_SIMT;
  assign reqWarp  = reqIf.ReqWarpID_Sched_SIMT;
  assign reqPc    = reqIf.ReqPCplus4_Sched_SIMT;
  assign reqMask  = reqIf.ReqMask_Sched_SIMT;

  simt_update_sched #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Valid_ID0_Sched     (v0),
    .WarpID_ID0_Sched    (w0),
    .Op_ID0_Sched        (op0),
    .PCplus4_ID0_Sched   (pc0),
    .Valid_ID1_Sched     (v1),
    .WarpID_ID1_Sched    (w1),
    .Op_ID1_Sched        (op1),
    .PCplus4_ID1_Sched   (pc1),
    .Br_ALU_Sched        (br),
    .WarpID_ALU_Sched    (bw),
    .BrOutcome_ALU_Sched (bm),
    .req                 (reqIf),
    .Stall_Sched_PC      (stall),
    .Overflow_Sched      (overflow)
`ifdef SCHED_PERF_CNT_EN
    ,
    .IssueCnt_Sched      (issueCnt),
    .StallCnt_Sched      (stallCnt)
`endif
  );

  typedef struct {
    logic [2:0]      op;
    logic [2:0]      warp;
    logic [PC_W-1:0] pc;
    logic [7:0]      mask;
  } req_t;

  typedef struct {
    logic            lane;
    logic [2:0]      op;
    logic [2:0]      warp;
    logic [PC_W-1:0] pc;
    logic            expValid;
    logic [2:0]      expOp;
    logic [2:0]      expWarp;
    logic [PC_W-1:0] expPc;
  } vec_t;

  req_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0; op0 = 3'd0; w0 = 3'd0; pc0 = '0;
    v1 = 1'b0; op1 = 3'd0; w1 = 3'd0; pc1 = '0;
    br = 1'b0; bw = 3'd0; bm = 8'd0;
  endtask

  task automatic setLane0(input logic [2:0] op, input logic [2:0] w, input logic [PC_W-1:0] pc);
    v0 = 1'b1; op0 = op; w0 = w; pc0 = pc;
  endtask

  task automatic setLane1(input logic [2:0] op, input logic [2:0] w, input logic [PC_W-1:0] pc);
    v1 = 1'b1; op1 = op; w1 = w; pc1 = pc;
  endtask

  task automatic setAlu(input logic [2:0] w, input logic [7:0] m);
    br = 1'b1; bw = w; bm = m;
  endtask

  task automatic pushExp(input logic [2:0] op, input logic [2:0] w, input logic [PC_W-1:0] pc,
                         input logic [7:0] m);
    req_t e;
    e.op = op; e.warp = w; e.pc = pc; e.mask = m;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    idle();
    if (v.lane) setLane1(v.op, v.warp, v.pc);
    else        setLane0(v.op, v.warp, v.pc);
    if (v.expValid) pushExp(v.expOp, v.expWarp, v.expPc, 8'd0);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, " drained"}, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  // Scoreboard: every handshake must match the oldest expected request.
  logic prevHeld = 1'b0;
  req_t prevReq;
  always @(negedge clk) begin
    req_t e;
    if (!rst) begin
      if (prevHeld)
        checkOutput("held payload", 64'({reqValid, reqOp, reqWarp, reqMask, reqPc}),
                    64'({1'b1, prevReq.op, prevReq.warp, prevReq.mask, prevReq.pc}));
      if (reqValid && ready) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected issue: got op %0d warp %0d, expected no request", reqOp, reqWarp);
        end else begin
          e = expQ.pop_front();
          checkOutput("issue", 64'({reqOp, reqWarp, reqMask, reqPc}),
                      64'({e.op, e.warp, e.mask, e.pc}));
        end
      end
    end
    prevHeld     = !rst && reqValid && !ready;
    prevReq.op   = reqOp;
    prevReq.warp = reqWarp;
    prevReq.pc   = reqPc;
    prevReq.mask = reqMask;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 3'd4, 3'd0, 32'h0000_1004, 1'b1, 3'd4, 3'd0, 32'h0000_1004};
    vecs[1] = '{1'b1, 3'd5, 3'd7, 32'h0000_2008, 1'b1, 3'd5, 3'd7, 32'h0000_2008};
    vecs[2] = '{1'b0, 3'd3, 3'd4, 32'hDEAD_BEEC, 1'b1, 3'd3, 3'd4, 32'hDEAD_BEEC};
    vecs[3] = '{1'b1, 3'd6, 3'd6, 32'h0000_0040, 1'b1, 3'd6, 3'd6, 32'h0000_0040};
    vecs[4] = '{1'b0, 3'd0, 3'd2, 32'h0000_3000, 1'b0, 3'd0, 3'd0, 32'h0000_0000};
    vecs[5] = '{1'b1, 3'd7, 3'd5, 32'h0000_4000, 1'b0, 3'd0, 3'd0, 32'h0000_0000};
    vecs[6] = '{1'b0, 3'd7, 3'd1, 32'h0000_5000, 1'b0, 3'd0, 3'd0, 32'h0000_0000};

    rst = 1'b1;
    ready = 1'b0;
    idle();
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset valid", 64'(reqValid), 64'd0);
    checkOutput("reset payload", 64'({reqOp, reqWarp, reqMask, reqPc}), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
`ifdef SCHED_PERF_CNT_EN
    checkOutput("reset counters", 64'({issueCnt, stallCnt}), 64'd0);
`endif
    tick();
    rst = 1'b0;

    // Branch then its outcome: stall holds until the outcome handshakes.
    ready = 1'b1;
    tick();
    setLane0(3'd1, 3'd3, 32'h0000_0104);
    pushExp(3'd1, 3'd3, 32'h0000_0104, 8'd0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("A head branch", 64'({reqValid, reqOp, reqWarp}), 64'({1'b1, 3'd1, 3'd3}));
    checkOutput("A stall after branch", 64'(stall), 64'h08);
    tick();
    setAlu(3'd3, 8'hA5);
    pushExp(3'd7, 3'd3, '0, 8'hA5);
    @(negedge clk);
    checkOutput("A stall before outcome", 64'(stall), 64'h08);
    tick();
    idle();
    @(negedge clk);
    checkOutput("A head outcome", 64'({reqValid, reqOp, reqWarp, reqMask}), 64'({1'b1, 3'd7, 3'd3, 8'hA5}));
    checkOutput("A stall during outcome", 64'(stall), 64'h08);
    tick();
    @(negedge clk);
    checkOutput("A stall cleared", 64'(stall), 64'h00);
    waitDrain("A", 10);

    // Single-op vectors, including ignored opcodes 0 and 7.
    for (int i = 0; i < 7; i++) begin
      tick();
      applyStimulus(vecs[i]);
      tick();
      idle();
      @(negedge clk);
      checkOutput($sformatf("vec%0d head", i), 64'({reqValid, reqOp, reqWarp, reqPc}),
                  64'({vecs[i].expValid, vecs[i].expOp, vecs[i].expWarp, vecs[i].expPc}));
      waitDrain($sformatf("vec%0d", i), 10);
      checkOutput($sformatf("vec%0d stall", i), 64'(stall), 64'h00);
    end

    // Dual-lane push issues lane 0 then lane 1 on consecutive cycles.
    tick();
    setLane0(3'd4, 3'd1, 32'h0000_0200);
    setLane1(3'd6, 3'd2, 32'h0000_0300);
    pushExp(3'd4, 3'd1, 32'h0000_0200, 8'd0);
    pushExp(3'd6, 3'd2, 32'h0000_0300, 8'd0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("B first issue", 64'({reqValid, reqOp, reqWarp}), 64'({1'b1, 3'd4, 3'd1}));
    tick();
    @(negedge clk);
    checkOutput("B second issue", 64'({reqValid, reqOp, reqWarp}), 64'({1'b1, 3'd6, 3'd2}));
    waitDrain("B", 10);

    // Outcome behind its own queued branch waits; branch payload holds while not ready.
    ready = 1'b0;
    tick();
    setLane0(3'd2, 3'd5, 32'h0000_0504);
    pushExp(3'd2, 3'd5, 32'h0000_0504, 8'd0);
    tick();
    idle();
    setAlu(3'd5, 8'h3C);
    pushExp(3'd7, 3'd5, '0, 8'h3C);
    tick();
    idle();
    @(negedge clk);
    checkOutput("C held branch", 64'({reqValid, reqOp, reqWarp, reqPc}), 64'({1'b1, 3'd2, 3'd5, 32'h0000_0504}));
    checkOutput("C stall pending", 64'(stall), 64'h20);
    tick();
    ready = 1'b1;
    @(negedge clk);
    checkOutput("C branch issues first", 64'({reqValid, reqOp, reqWarp}), 64'({1'b1, 3'd2, 3'd5}));
    tick();
    @(negedge clk);
    checkOutput("C outcome next", 64'({reqValid, reqOp, reqWarp, reqMask}), 64'({1'b1, 3'd7, 3'd5, 8'h3C}));
    checkOutput("C stall until outcome", 64'(stall), 64'h20);
    tick();
    @(negedge clk);
    checkOutput("C stall cleared", 64'(stall), 64'h00);
    checkOutput("C idle", 64'(reqValid), 64'd0);
    waitDrain("C", 10);

    // Fill to one free slot, then a dual push drops lane 1.
    ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      idle();
      setLane0(3'd4, 3'(i), 32'h0000_1000 + 32'(4 * i));
      pushExp(3'd4, 3'(i), 32'h0000_1000 + 32'(4 * i), 8'd0);
      if (i == DEPTH - 2) begin
        @(negedge clk);
        checkOutput("D stall at two free", 64'(stall), 64'h00);
      end
    end
    tick();
    idle();
    @(negedge clk);
    checkOutput("D stall at one free", 64'(stall), 64'hFF);
    checkOutput("D no overflow yet", 64'(overflow), 64'd0);
    tick();
    setLane0(3'd5, 3'd6, 32'h0000_2000);
    setLane1(3'd6, 3'd7, 32'h0000_3000);
    pushExp(3'd5, 3'd6, 32'h0000_2000, 8'd0);
    tick();
    idle();
    @(negedge clk);
    checkOutput("D overflow set", 64'(overflow), 64'd1);
    checkOutput("D stall full", 64'(stall), 64'hFF);
    tick();
    @(negedge clk);
    checkOutput("D overflow sticky", 64'(overflow), 64'd1);
    tick();
    ready = 1'b1;
    waitDrain("D", 30);
    @(negedge clk);
    checkOutput("D overflow after drain", 64'(overflow), 64'd1);
    checkOutput("D stall after drain", 64'(stall), 64'h00);

    // Reset with queued work and pending branches.
    ready = 1'b0;
    tick();
    setLane0(3'd1, 3'd1, 32'h0000_0010);
    setLane1(3'd2, 3'd2, 32'h0000_0020);
    tick();
    idle();
    setLane0(3'd4, 3'd0, 32'h0000_0030);
    tick();
    idle();
    @(negedge clk);
    checkOutput("E stall pending", 64'(stall), 64'h06);
    checkOutput("E queued head", 64'({reqValid, reqOp, reqWarp}), 64'({1'b1, 3'd1, 3'd1}));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("E reset valid", 64'(reqValid), 64'd0);
    checkOutput("E reset payload", 64'({reqOp, reqWarp, reqMask, reqPc}), 64'd0);
    checkOutput("E reset stall", 64'(stall), 64'd0);
    checkOutput("E reset overflow", 64'(overflow), 64'd0);
    tick();
    rst = 1'b0;
    ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    checkOutput("E nothing after reset", 64'(reqValid), 64'd0);

`ifdef SCHED_PERF_CNT_EN
    // Four issues behind two not-ready cycles.
    checkOutput("P counters cleared", 64'({issueCnt, stallCnt}), 64'd0);
    ready = 1'b0;
    tick();
    setLane0(3'd4, 3'd0, 32'h0000_0100);
    setLane1(3'd4, 3'd1, 32'h0000_0104);
    pushExp(3'd4, 3'd0, 32'h0000_0100, 8'd0);
    pushExp(3'd4, 3'd1, 32'h0000_0104, 8'd0);
    tick();
    idle();
    setLane0(3'd4, 3'd2, 32'h0000_0108);
    setLane1(3'd4, 3'd3, 32'h0000_010C);
    pushExp(3'd4, 3'd2, 32'h0000_0108, 8'd0);
    pushExp(3'd4, 3'd3, 32'h0000_010C, 8'd0);
    tick();
    idle();
    tick();
    ready = 1'b1;
    waitDrain("P", 20);
    @(negedge clk);
    checkOutput("P issue count", 64'(issueCnt), 64'd4);
    checkOutput("P stall count", 64'(stallCnt), 64'd2);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/simt_update_sched.md
Name: simt_update_sched

Overview:
- Front-end scheduler for the SIMT stack: collects control-flow requests from both decode lanes (ID0, ID1) and branch outcomes from the ALU.
- Serialises them onto the stack's single update port with a valid/ready handshake.
- Enforces per-warp ordering between a branch and its outcome.
- Generates per-warp fetch stalls while a warp's conditional branch is unresolved or the queue is nearly full.

Parameters:
- DEPTH, 8: decode request FIFO entries (power of 2, >=4).
- PC_W, 32: PC+4 width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- Valid_ID0_Sched  in  1  lane 0 carries a control-flow op.
- WarpID_ID0_Sched  in  3  lane 0 warp.
- Op_ID0_Sched  in  3  lane 0 op: 1 BEQ, 2 BLT, 3 DotS, 4 Call, 5 Ret, 6 Jmp; 0/7 ignored.
- PCplus4_ID0_Sched  in  PC_W  lane 0 PC+4.
- Valid_ID1_Sched / WarpID_ID1_Sched / Op_ID1_Sched / PCplus4_ID1_Sched  in  1/3/3/PC_W  lane 1, same meaning.
- Br_ALU_Sched  in  1  branch outcome valid.
- WarpID_ALU_Sched  in  3  outcome warp.
- BrOutcome_ALU_Sched  in  8  per-thread taken mask.
- ReqValid_Sched_SIMT  out  1  request valid.
- ReqReady_SIMT_Sched  in  1  stack accepts.
- ReqOp_Sched_SIMT  out  3  op; 7 = ALU outcome.
- ReqWarpID_Sched_SIMT  out  3  warp.
- ReqPCplus4_Sched_SIMT  out  PC_W  PC+4; 0 for outcomes.
- ReqMask_Sched_SIMT  out  8  outcome mask; 0 for decode ops.
- Stall_Sched_PC  out  8  per-warp fetch stall.
- Overflow_Sched  out  1  sticky: request dropped.

Behaviour:
- Reset: FIFO empty; ALU buffer empty; pending[7:0]=0; all outputs 0. Reset mid-operation discards all queued requests.
- Enqueue: valid lanes with op 1..6 are pushed the same cycle. If both lanes are valid, ID0 takes the lower slot and ID1 the next. A lane that finds no free slot is dropped and sets Overflow_Sched; ID0 has priority for the last free slot.
- ALU buffer: 2-entry FIFO. A push when full drops the outcome and sets Overflow_Sched.
- pending[w]: set the cycle a BEQ/BLT for warp w is enqueued. Cleared the cycle an outcome for w completes its handshake. If set and clear coincide, set wins.
- brq[w]: set while any BEQ/BLT for warp w sits in the decode FIFO. Recomputed from FIFO contents each cycle or tracked as a per-warp counter.
- Issue arbitration, one request per cycle:
  - The ALU buffer head wins if !brq[head warp].
  - Otherwise the decode FIFO head issues if non-empty.
  - A blocked ALU head never blocks the FIFO, so no deadlock.
- Outputs: registered from the selected head. Zero-latency from head to port, i.e. combinational head select of registered storage.
- Handshake: pop only on ReqValid & ReqReady. Payload stays stable while valid and not ready. Simultaneous push and pop of the FIFO is allowed when full.
- Stall_Sched_PC[w] = pending[w] | (free slots < 2), where free is computed from registered counts.
- An outcome for a warp with pending=0 is still issued and has no effect on pending.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

Optional Feature:
- SCHED_PERF_CNT_EN defined:
  - Adds outputs IssueCnt_Sched [15:0] and StallCnt_Sched [15:0], reset to 0.
  - IssueCnt increments per completed handshake.
  - StallCnt increments each cycle ReqValid & !ReqReady.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Reset, then ID0 BEQ warp 3 with ready=1 -> next cycle ReqOp=1, Warp=3; Stall_Sched_PC=8'h08 until the outcome (warp 3, mask 8'hA5) issues with ReqOp=7, ReqMask=A5; then Stall=0.
- ID0 Call warp 1 and ID1 Jmp warp 2 in the same cycle, ready=1 -> issue order Call(w1) then Jmp(w2) on consecutive cycles.
- Ready=0, push BLT w5, then ALU outcome w5 -> head holds BLT stable. After ready=1: BLT issues first, outcome the cycle after; pending[5] clears on the outcome handshake.
- Ready=0, push DEPTH-1 entries -> Stall=8'hFF. A dual push at 1 free slot -> ID0 accepted, ID1 dropped, Overflow_Sched=1 and sticky.
- Assert rst with 3 queued entries and pending=8'h06 -> the next cycle all outputs are 0 and nothing issues after rst deasserts.
- SCHED_PERF_CNT_EN: 4 issues with 2 not-ready cycles -> IssueCnt=4, StallCnt=2.
